// File: rtl/hilo_muldiv_unit.sv
// HI/LO architectural register pair with pipelined multiplier and restoring divider.
// Latency: MTHI/MTLO and divide-by-zero 1 cycle, MULT/MULTU MUL_STAGES cycles, DIV/DIVU DATA_W+1 cycles.
// Backpressure: start_i is ignored while busy_o=1; flush_i kills an in-flight op without writing HI/LO.
module hilo_muldiv_unit #(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // The HI/LO pair acts as the final multiplier stage, so only MUL_STAGES-1
  // product registers are needed; one unused stage register exists when MUL_STAGES=1.
  localparam int PIPE_N = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIV_RUN = 2'd1,
    S_DIV_FIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [PIPE_N-1:0]   mul_vld_q, mul_vld_d;
  logic [PROD_W-1:0]   mul_prod_q [PIPE_N];
  logic [PROD_W-1:0]   mul_prod_d [PIPE_N];

  // Operand preparation shared by the accept path.
  logic                mul_signed;
  logic [PROD_W-1:0]   mul_a_ext;
  logic [PROD_W-1:0]   mul_b_ext;
  logic [PROD_W-1:0]   mul_prod_in;
  logic                div_signed;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic                accept;
  logic                mul_tail;

  // One restoring-divider step on the current partial remainder.
  logic [DATA_W:0]     rem_shift;
  logic [DATA_W:0]     rem_trial;
  logic                quo_bit;
  logic [DATA_W-1:0]   rem_next;
  logic [DATA_W-1:0]   quo_next;

  assign busy_o = (state_q == S_DIV_RUN) | (|mul_vld_q);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  // Sign/zero extension to 2*DATA_W makes one multiplier serve both MULT and MULTU.
  always_comb begin
    mul_signed  = (op_i == OP_MULT);
    mul_a_ext   = mul_signed ? {{DATA_W{a_i[DATA_W-1]}}, a_i} : {{DATA_W{1'b0}}, a_i};
    mul_b_ext   = mul_signed ? {{DATA_W{b_i[DATA_W-1]}}, b_i} : {{DATA_W{1'b0}}, b_i};
    mul_prod_in = mul_a_ext * mul_b_ext;
    div_signed  = (op_i == OP_DIV);
    a_mag       = (div_signed && a_i[DATA_W-1]) ? (~a_i + 1'b1) : a_i;
    b_mag       = (div_signed && b_i[DATA_W-1]) ? (~b_i + 1'b1) : b_i;
    accept      = start_i && !busy_o && !flush_i;
    mul_tail    = (MUL_STAGES > 1) && mul_vld_q[PIPE_N-1];
  end

  // Divider datapath: shift in the next dividend bit and subtract when it fits.
  always_comb begin
    rem_shift = {rem_q, quo_q[DATA_W-1]};
    rem_trial = rem_shift - {1'b0, dvs_q};
    quo_bit   = !rem_trial[DATA_W];
    rem_next  = quo_bit ? rem_trial[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    quo_next  = {quo_q[DATA_W-2:0], quo_bit};
  end

  // Next-state logic: multiplier retire, divider FSM, then new-op accept.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    mul_vld_d     = '0;
    mul_prod_d[0] = mul_prod_q[0];
    for (int k = PIPE_N - 1; k >= 1; k--) begin
      mul_vld_d[k]  = mul_vld_q[k-1];
      mul_prod_d[k] = mul_prod_q[k-1];
    end

    if (mul_tail && !flush_i) begin
      hi_d   = mul_prod_q[PIPE_N-1][PROD_W-1:DATA_W];
      lo_d   = mul_prod_q[PIPE_N-1][DATA_W-1:0];
      done_d = 1'b1;
    end
    if (flush_i) begin
      mul_vld_d = '0;
    end

    case (state_q)
      S_DIV_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          quo_d = quo_next;
          rem_d = rem_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            // Last bit resolved: sign-correct and commit so DIV_FIN is the done cycle.
            state_d = S_DIV_FIN;
            lo_d    = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
            hi_d    = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
            done_d  = 1'b1;
          end
        end
      end
      S_DIV_FIN: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (accept) begin
      case (op_i)
        OP_MULT, OP_MULTU: begin
          if (MUL_STAGES == 1) begin
            hi_d   = mul_prod_in[PROD_W-1:DATA_W];
            lo_d   = mul_prod_in[DATA_W-1:0];
            done_d = 1'b1;
          end else begin
            mul_vld_d[0]  = 1'b1;
            mul_prod_d[0] = mul_prod_in;
          end
        end
        OP_DIV, OP_DIVU: begin
          if (b_i == '0) begin
            hi_d   = a_i;
            lo_d   = '1;
            done_d = 1'b1;
          end else begin
            state_d   = S_DIV_RUN;
            cnt_d     = CNT_W'(DATA_W - 1);
            quo_d     = a_mag;
            rem_d     = '0;
            dvs_d     = b_mag;
            neg_quo_d = div_signed && (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
            neg_rem_d = div_signed && a_i[DATA_W-1];
          end
        end
        OP_MTHI: begin
          hi_d   = a_i;
          done_d = 1'b1;
        end
        OP_MTLO: begin
          lo_d   = a_i;
          done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State registers; reset discards any in-flight op.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mul_vld_q <= '0;
      for (int k = 0; k < PIPE_N; k++) begin
        mul_prod_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      mul_vld_q <= mul_vld_d;
      for (int k = 0; k < PIPE_N; k++) begin
        mul_prod_q[k] <= mul_prod_d[k];
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit with DATA_W=32, MUL_STAGES=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Every wait on done_o is bounded; an expired bound shows up as a failed comparison.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_err;

  hilo_muldiv_unit #(.DATA_W(32), .MUL_STAGES(2)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .flush_i(flush),
    .busy_o (busy),
    .done_o (done),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; returns positioned in cycle T+1.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
  endtask

  // Issue a divide and wait for done; returns positioned in the done cycle.
  task automatic run_div(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output int done_at, output int busy_n);
    issue(o, av, bv);
    done_at = 0;
    busy_n  = 0;
    for (int i = 1; i <= 60; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_at = i;
        break;
      end
      tick();
    end
  endtask

  int done_at;
  int busy_n;
  int nd;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // MTHI then MTLO on consecutive cycles
    issue(3'd4, 32'h12345678, 0);
    chk("mthi_done", done, 1);
    chk("mthi_busy", busy, 0);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, 0);
    issue(3'd5, 32'h9ABCDEF0, 0);
    chk("mtlo_done", done, 1);
    chk("mtlo_busy", busy, 0);
    chk("mtlo_hi", hi, 32'h12345678);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    tick();
    chk("mt_done_drop", done, 0);

    // MULT / MULTU with -1 * 2
    issue(3'd0, 32'hFFFFFFFF, 32'h2);
    chk("mult_busy_t1", busy, 1);
    chk("mult_done_t1", done, 0);
    tick();
    chk("mult_done_t2", done, 1);
    chk("mult_busy_t2", busy, 0);
    chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    issue(3'd1, 32'hFFFFFFFF, 32'h2);
    tick();
    chk("multu_done", done, 1);
    chk("multu_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);

    // MULT killed by flush while busy
    issue(3'd1, 32'h3, 32'h3);
    chk("mulfl_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("mulfl_done", done, 0);
    chk("mulfl_busy_after", busy, 0);
    chk("mulfl_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);
    tick();
    chk("mulfl_done2", done, 0);

    // Signed divides
    run_div(3'd2, 32'hFFFFFFF9, 32'h2, done_at, busy_n);
    chk("div_m7_done_at", done_at, 33);
    chk("div_m7_busy_n", busy_n, 32);
    chk("div_m7_busy_fin", busy, 0);
    chk("div_m7_lo", lo, 32'hFFFFFFFD);
    chk("div_m7_hi", hi, 32'hFFFFFFFF);
    tick();
    chk("div_m7_done_once", done, 0);
    run_div(3'd2, 32'h80000000, 32'hFFFFFFFF, done_at, busy_n);
    chk("div_ovf_done_at", done_at, 33);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h0);
    run_div(3'd2, 32'h7, 32'hFFFFFFFE, done_at, busy_n);
    chk("div_7_m2_lo", lo, 32'hFFFFFFFD);
    chk("div_7_m2_hi", hi, 32'h1);
    run_div(3'd3, 32'd100, 32'd7, done_at, busy_n);
    chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    // back-to-back start in the done cycle
    issue(3'd5, 32'h55, 0);
    chk("b2b_done", done, 1);
    chk("b2b_lo", lo, 32'h55);
    chk("b2b_hi", hi, 32'd2);

    // Divide by zero
    issue(3'd3, 32'd100, 32'd0);
    chk("dz_done", done, 1);
    chk("dz_busy", busy, 0);
    chk("dz_hilo", {hi, lo}, {32'd100, 32'hFFFFFFFF});

    // Start together with flush is dropped
    start = 1'b1;
    flush = 1'b1;
    op    = 3'd4;
    a     = 32'h1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    chk("stfl_done", done, 0);
    chk("stfl_hi", hi, 32'd100);

    // Reserved opcode ignored
    issue(3'd6, 32'h1, 32'h1);
    chk("rsv_busy", busy, 0);
    chk("rsv_done", done, 0);
    chk("rsv_hilo", {hi, lo}, {32'd100, 32'hFFFFFFFF});

    // DIVU flushed at T+10
    issue(3'd3, 32'd50, 32'd7);
    nd = 0;
    for (int i = 1; i < 10; i++) begin
      if (done) nd++;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("dfl_busy", busy, 0);
    chk("dfl_ndone", nd + int'(done), 0);
    chk("dfl_hilo", {hi, lo}, {32'd100, 32'hFFFFFFFF});
    run_div(3'd3, 32'd50, 32'd7, done_at, busy_n);
    chk("dfl_restart_at", done_at, 33);
    chk("dfl_restart_hilo", {hi, lo}, {32'd1, 32'd7});

    // MULTU issued while DIV busy is ignored
    issue(3'd3, 32'd20, 32'd3);
    nd = 0;
    done_at = 0;
    for (int i = 1; i <= 45; i++) begin
      if (done) begin
        nd++;
        if (done_at == 0) done_at = i;
      end
      start = (i == 5);
      op    = 3'd1;
      a     = 32'd3;
      b     = 32'd5;
      tick();
    end
    start = 1'b0;
    chk("busy_ign_ndone", nd, 1);
    chk("busy_ign_at", done_at, 33);
    chk("busy_ign_hilo", {hi, lo}, {32'd2, 32'd6});

    // Reset mid-divide
    issue(3'd3, 32'd50, 32'd7);
    for (int i = 1; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstdiv_hilo", {hi, lo}, 64'h0);
    chk("rstdiv_busy", busy, 0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      tick();
    end
    chk("rstdiv_ndone", nd, 0);
    chk("rstdiv_hilo_end", {hi, lo}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised successor to the plain HI/LO register stage.
- Holds the architectural HI/LO pair and owns the multi-cycle multiply and divide engines that write it.
- Sits in WB/EX: the EX stage issues an operation with a start pulse, and the unit raises busy while the op is in flight.
- ID reads hi_o/lo_o directly; they update on the cycle done_o pulses.

Parameters:
- DATA_W, 32, width of operands, HI and LO.
- MUL_STAGES, 2, multiplier pipeline depth in cycles; legal range is 1..4.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- start_i  input  1  issue request; sampled only when busy_o=0.
- op_i  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 reserved.
- a_i  input  DATA_W  operand A (dividend / multiplicand / MTxx source).
- b_i  input  DATA_W  operand B (divisor / multiplier).
- flush_i  input  1  exception flush; cancels any in-flight op.
- busy_o  output  1  high while an accepted op is outstanding.
- done_o  output  1  one-cycle pulse in the cycle new HI/LO values first appear.
- hi_o  output  DATA_W  architectural HI.
- lo_o  output  DATA_W  architectural LO.

Behaviour:
- Reset: hi_o=0, lo_o=0, busy_o=0, done_o=0, FSM=IDLE, all pipeline valid bits cleared. Reset mid-operation discards the op with no HI/LO write.
- Accept: in cycle T, start_i=1, busy_o=0 and flush_i=0 accepts the op; operands are latched at the T edge.
  - Reserved op codes are ignored: no busy, no done, no write.
  - start_i while busy_o=1 is ignored.
- MTHI/MTLO: HI (or LO) <= a_i at the T edge. done_o=1 in T+1. busy_o stays 0. The other register is unchanged.
- MULT/MULTU: full 2*DATA_W product. HI = upper half, LO = lower half. MULT uses signed operands, MULTU unsigned.
  - busy_o=1 from T+1 to T+MUL_STAGES-1 (never high when MUL_STAGES=1).
  - HI/LO are written at the edge ending T+MUL_STAGES-1; done_o=1 and new values visible in T+MUL_STAGES.
- DIV/DIVU: restoring divider, one quotient bit per cycle. FSM states are IDLE, DIV_RUN, DIV_FIN.
  - T+1 .. T+DATA_W are in DIV_RUN with a bit counter from DATA_W-1 down to 0.
  - DIV_FIN applies sign correction and writes LO=quotient, HI=remainder.
  - done_o=1 in T+DATA_W+1; busy_o=1 from T+1 to T+DATA_W.
  - Signed: operate on magnitudes. Negate the quotient iff operand signs differ; the remainder takes the dividend's sign.
  - Most-negative / -1 gives quotient = most-negative (wrap) and remainder = 0, with no special case.
- Divide by zero (b_i=0, DIV or DIVU): skip DIV_RUN. HI=a_i, LO=all ones. done_o=1 in T+1. busy_o stays 0.
- Back-to-back: a new start is legal in the same cycle done_o=1, because busy_o is already 0 then.
- flush_i:
  - In the same cycle as start_i, the start is ignored.
  - While busy_o=1, the op is killed: no HI/LO write, no done_o, busy_o=0 from the next cycle, FSM returns to IDLE, multiplier pipeline valids are cleared.
  - In a done_o cycle, no effect: the write has already happened.
- Simultaneous rst_i and anything else: reset wins.
- done_o is never high for two consecutive cycles from the same op.

Test Plan:
- Reset, then MTHI a=0x12345678 followed next cycle by MTLO a=0x9ABCDEF0 -> hi_o=0x12345678 and lo_o=0x9ABCDEF0, with done_o high in each following cycle and busy_o never high.
- MULT a=0xFFFFFFFF (-1), b=0x00000002 -> done_o in T+2, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE. MULTU with the same operands -> hi_o=0x00000001, lo_o=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy_o high for cycles T+1..T+32, done_o in T+33, lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1). DIV a=0x80000000, b=0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIVU a=100, b=0 -> done_o in T+1, hi_o=100, lo_o=0xFFFFFFFF, busy_o never high.
- Start DIVU 50/7, assert flush_i at T+10 -> busy_o=0 at T+11, no done_o, hi_o/lo_o keep their prior values. A start at T+11 is accepted.
- Start MULTU while DIV is busy -> the MULTU is ignored and only the DIV result is written. Assert rst_i mid-DIV -> hi_o=lo_o=0 and no done_o follows.
